// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the programmable serial sequence detector.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_MAX_LEN = 8;
  localparam int unsigned DEFAULT_CNT_W   = 8;
  // Wide enough for any MAX_LEN up to 16.
  localparam int unsigned LEN_W           = 5;

  // A zero length behaves as a single-bit pattern; oversize lengths saturate.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                 input int unsigned       max_len);
    if (len == '0) return LEN_W'(1);
    if (32'(len) > max_len) return LEN_W'(max_len);
    return len;
  endfunction

endpackage

// File: rtl/seq_detect_ctrl_match_core.sv
// Shift register, fill counter and length-masked compare. The match strobe is
// combinational and describes the bit being sampled on the coming edge.
module seq_match_core
  import seq_detect_pkg::*;
#(
  parameter int unsigned MAX_LEN = DEFAULT_MAX_LEN
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               sample,
  input  logic               inbits,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic               overlap,
  output logic               match
);

  logic [MAX_LEN-1:0] sr_q, sr_next, mask;
  logic [LEN_W-1:0]   fill_q, fill_next;

  // Next shift/fill values and the masked compare against the pattern.
  always_comb begin
    sr_next   = {sr_q[MAX_LEN-2:0], inbits};
    fill_next = (fill_q >= len) ? len : fill_q + LEN_W'(1);
    mask      = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
    match = sample && (fill_next >= len) && ((sr_next & mask) == (pattern & mask));
  end

  // Shift on every accepted sample; non-overlapping mode restarts the fill on a hit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q   <= '0;
      fill_q <= '0;
    end else if (clear) begin
      sr_q   <= '0;
      fill_q <= '0;
    end else if (sample) begin
      sr_q   <= sr_next;
      fill_q <= (match && !overlap) ? '0 : fill_next;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Programmable serial sequence-detection controller: config latch, IDLE/RUN/DONE
// sequencing, hit counting with optional match-limit stop.
// Optional feature macro: SEQ_DETECT_STICKY_EN adds irq_clr/irq sticky interrupt.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int unsigned MAX_LEN = DEFAULT_MAX_LEN,
  parameter int unsigned CNT_W   = DEFAULT_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   match_limit,
  input  logic               start,
  input  logic               stop,
  input  logic               inbits,
  output logic               detect,
  output logic [CNT_W-1:0]   hit_count,
  output logic               busy,
  output logic               done
`ifdef SEQ_DETECT_STICKY_EN
  ,
  input  logic               irq_clr,
  output logic               irq
`endif
);

  state_e             state_q;
  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  logic [CNT_W-1:0]   limit_q;

  logic               match;
  logic               run_sample;
  logic               core_clear;
  logic [CNT_W-1:0]   hit_inc;
  logic               limit_hit;

  // Run-control strobes; stop suppresses the sample so it can never count.
  always_comb begin
    run_sample = (state_q == StRun) && !stop;
    core_clear = start && (state_q != StRun);
    hit_inc    = (hit_count == '1) ? hit_count : hit_count + CNT_W'(1);
    limit_hit  = (limit_q != '0) && (hit_inc == limit_q);
  end

  seq_match_core #(
    .MAX_LEN(MAX_LEN)
  ) u_match_core (
    .clk    (clk),
    .reset  (reset),
    .clear  (core_clear),
    .sample (run_sample),
    .inbits (inbits),
    .pattern(pattern_q),
    .len    (clamp_len(len_q, MAX_LEN)),
    .overlap(overlap_q),
    .match  (match)
  );

  // Controller FSM with registered status outputs, config latch and hit counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      pattern_q <= '0;
      len_q     <= '0;
      overlap_q <= 1'b0;
      limit_q   <= '0;
      detect    <= 1'b0;
      hit_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_ready <= 1'b1;
    end else begin
      detect <= 1'b0;
      if (cfg_valid && cfg_ready) begin
        pattern_q <= cfg_pattern;
        len_q     <= cfg_len;
        overlap_q <= cfg_overlap;
        limit_q   <= match_limit;
      end
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q   <= StRun;
            hit_count <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            cfg_ready <= 1'b0;
          end else if (stop && (state_q == StDone)) begin
            state_q <= StIdle;
            done    <= 1'b0;
          end
        end
        StRun: begin
          if (stop) begin
            state_q   <= StIdle;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
          end else if (match) begin
            detect    <= 1'b1;
            hit_count <= hit_inc;
            if (limit_hit) begin
              state_q   <= StDone;
              busy      <= 1'b0;
              done      <= 1'b1;
              cfg_ready <= 1'b1;
            end
          end
        end
        default: begin
          state_q   <= StIdle;
          busy      <= 1'b0;
          done      <= 1'b0;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef SEQ_DETECT_STICKY_EN
  logic irq_set;
  // Every limit stop is entered through a match, so the match covers both set causes.
  assign irq_set = match;

  // Sticky interrupt: a set in the same cycle as a clear takes priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq <= 1'b0;
    end else if (irq_set) begin
      irq <= 1'b1;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end
  end
`endif

endmodule
